// File: rtl/cfg_vpd_req_seq.sv
// VPD request sequencer: PCIe VPD capability registers in front of the
// hold-until-done cfg_vpd_* port, with completion timeout and sticky errors.
module cfg_vpd_req_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clock_tlx,
  input  logic        reset,
  input  logic        cap_addr_wr,
  input  logic [15:0] cap_addr_wdata,
  input  logic        cap_data_wr,
  input  logic [31:0] cap_data_wdata,
  output logic [15:0] cap_addr_rdata,
  output logic [31:0] cap_data_rdata,
  output logic [14:0] cfg_vpd_addr,
  output logic        cfg_vpd_wren,
  output logic [31:0] cfg_vpd_wdata,
  output logic        cfg_vpd_rden,
  input  logic [31:0] vpd_cfg_rdata,
  input  logic        vpd_cfg_done,
  input  logic        vpd_err_unimplemented_addr,
  input  logic        err_clear,
  output logic        vpd_busy,
  output logic [2:0]  vpd_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t             state, state_n;
  logic               f_q, f_n;
  logic [14:0]        addr_q, addr_n;
  logic [31:0]        data_q, data_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [2:0]         err_q, err_n, err_set;

  // State and register file; handshake outputs are flops fed from next state
  always_ff @(posedge clock_tlx or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      f_q          <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      cfg_vpd_wren <= 1'b0;
      cfg_vpd_rden <= 1'b0;
      vpd_busy     <= 1'b0;
    end else begin
      state        <= state_n;
      f_q          <= f_n;
      addr_q       <= addr_n;
      data_q       <= data_n;
      cnt_q        <= cnt_n;
      err_q        <= err_n;
      cfg_vpd_wren <= (state_n == WRITE);
      cfg_vpd_rden <= (state_n == READ);
      vpd_busy     <= (state_n != IDLE);
    end
  end

  // Next-state, register updates and error events
  always_comb begin
    state_n = state;
    f_n     = f_q;
    addr_n  = addr_q;
    data_n  = data_q;
    cnt_n   = cnt_q;
    err_set = 3'b000;

    case (state)
      IDLE: begin
        if (cap_data_wr) data_n = cap_data_wdata;
        if (cap_addr_wr) begin
          f_n     = cap_addr_wdata[15];
          addr_n  = cap_addr_wdata[14:0];
          cnt_n   = '0;
          state_n = cap_addr_wdata[15] ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        if (cap_addr_wr || cap_data_wr) err_set[2] = 1'b1;
        if (vpd_err_unimplemented_addr) err_set[1] = 1'b1;
        cnt_n = cnt_q + CNT_W'(1);
        // done takes priority over a timeout expiring in the same cycle
        if (vpd_cfg_done) begin
          if (state == WRITE) begin
            f_n = 1'b0;
          end else begin
            f_n    = 1'b1;
            data_n = vpd_cfg_rdata;
          end
          state_n = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_set[0] = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    err_n = (err_q & ~{3{err_clear}}) | err_set;
  end

  assign cap_addr_rdata = {f_q, addr_q};
  assign cap_data_rdata = data_q;
  assign cfg_vpd_addr   = addr_q;
  assign cfg_vpd_wdata  = data_q;
  assign vpd_err        = err_q;

endmodule

// File: tb/tb_cfg_vpd_req_seq.sv
// Directed self-checking bench for cfg_vpd_req_seq (TIMEOUT_CYCLES = 8).
module tb_cfg_vpd_req_seq;

  logic        clock_tlx = 1'b0;
  logic        reset = 1'b1;
  logic        cap_addr_wr = 1'b0;
  logic [15:0] cap_addr_wdata = '0;
  logic        cap_data_wr = 1'b0;
  logic [31:0] cap_data_wdata = '0;
  logic [15:0] cap_addr_rdata;
  logic [31:0] cap_data_rdata;
  logic [14:0] cfg_vpd_addr;
  logic        cfg_vpd_wren;
  logic [31:0] cfg_vpd_wdata;
  logic        cfg_vpd_rden;
  logic [31:0] vpd_cfg_rdata = '0;
  logic        vpd_cfg_done = 1'b0;
  logic        vpd_err_unimplemented_addr = 1'b0;
  logic        err_clear = 1'b0;
  logic        vpd_busy;
  logic [2:0]  vpd_err;

  int n_cmp = 0;
  int n_err = 0;

  cfg_vpd_req_seq #(.TIMEOUT_CYCLES(8)) dut (
    .clock_tlx                  (clock_tlx),
    .reset                      (reset),
    .cap_addr_wr                (cap_addr_wr),
    .cap_addr_wdata             (cap_addr_wdata),
    .cap_data_wr                (cap_data_wr),
    .cap_data_wdata             (cap_data_wdata),
    .cap_addr_rdata             (cap_addr_rdata),
    .cap_data_rdata             (cap_data_rdata),
    .cfg_vpd_addr               (cfg_vpd_addr),
    .cfg_vpd_wren               (cfg_vpd_wren),
    .cfg_vpd_wdata              (cfg_vpd_wdata),
    .cfg_vpd_rden               (cfg_vpd_rden),
    .vpd_cfg_rdata              (vpd_cfg_rdata),
    .vpd_cfg_done               (vpd_cfg_done),
    .vpd_err_unimplemented_addr (vpd_err_unimplemented_addr),
    .err_clear                  (err_clear),
    .vpd_busy                   (vpd_busy),
    .vpd_err                    (vpd_err)
  );

  always #5 clock_tlx = ~clock_tlx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(negedge clock_tlx);
  endtask

  task automatic addr_wr(input logic [15:0] v);
    cap_addr_wr = 1'b1; cap_addr_wdata = v;
    tick();
    cap_addr_wr = 1'b0;
  endtask

  task automatic data_wr(input logic [31:0] v);
    cap_data_wr = 1'b1; cap_data_wdata = v;
    tick();
    cap_data_wr = 1'b0;
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  int hi;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_wren",  32'(cfg_vpd_wren),   32'h0);
    chk("rst_rden",  32'(cfg_vpd_rden),   32'h0);
    chk("rst_busy",  32'(vpd_busy),       32'h0);
    chk("rst_addr",  32'(cfg_vpd_addr),   32'h0);
    chk("rst_wdata", cfg_vpd_wdata,       32'h0);
    chk("rst_ardata",32'(cap_addr_rdata), 32'h0);
    chk("rst_drdata",cap_data_rdata,      32'h0);
    chk("rst_err",   32'(vpd_err),        32'h0);

    // Read: done presented on the 6th request cycle
    addr_wr(16'h0010);
    chk("rd_addr", 32'(cfg_vpd_addr), 32'h010);
    chk("rd_busy", 32'(vpd_busy), 32'h1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (cfg_vpd_rden) hi++;
      if (i == 6) chk("rd_busy_after", 32'(vpd_busy), 32'h0);
      vpd_cfg_done  = (i == 5);
      vpd_cfg_rdata = (i == 5) ? 32'hA5A5_1234 : 32'h0;
      tick();
    end
    chk("rd_hi_cycles", 32'(hi), 32'd6);
    chk("rd_data",  cap_data_rdata,       32'hA5A5_1234);
    chk("rd_ardata",32'(cap_addr_rdata), 32'h8010);

    // Write, with a host data write dropped while busy and unimpl-addr on done
    data_wr(32'hDEAD_BEEF);
    addr_wr(16'h8123);
    chk("wr_wren",  32'(cfg_vpd_wren), 32'h1);
    chk("wr_rden",  32'(cfg_vpd_rden), 32'h0);
    chk("wr_addr",  32'(cfg_vpd_addr), 32'h123);
    chk("wr_wdata", cfg_vpd_wdata,     32'hDEAD_BEEF);
    data_wr(32'h1111_1111);
    chk("busy_wdata", cfg_vpd_wdata, 32'hDEAD_BEEF);
    chk("busy_err",   32'(vpd_err),  32'h4);
    chk("busy_wren",  32'(cfg_vpd_wren), 32'h1);
    vpd_cfg_done = 1'b1; vpd_err_unimplemented_addr = 1'b1;
    tick();
    vpd_cfg_done = 1'b0; vpd_err_unimplemented_addr = 1'b0;
    chk("wr_done_wren", 32'(cfg_vpd_wren), 32'h0);
    chk("wr_ardata",    32'(cap_addr_rdata), 32'h0123);
    chk("unimpl_err",   32'(vpd_err), 32'h6);
    clear_err();
    chk("clr_err", 32'(vpd_err), 32'h0);

    // Timeout: no done ever
    addr_wr(16'h0020);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (cfg_vpd_rden) hi++;
      tick();
    end
    chk("to_hi_cycles", 32'(hi), 32'd8);
    chk("to_err",    32'(vpd_err), 32'h1);
    chk("to_ardata", 32'(cap_addr_rdata), 32'h0020);
    chk("to_data",   cap_data_rdata, 32'hDEAD_BEEF);
    chk("to_busy",   32'(vpd_busy), 32'h0);
    clear_err();
    chk("to_clr", 32'(vpd_err), 32'h0);

    // Done on the same cycle the timeout would fire
    addr_wr(16'h0030);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (cfg_vpd_rden) hi++;
      vpd_cfg_done  = (i == 7);
      vpd_cfg_rdata = (i == 7) ? 32'h1234_5678 : 32'h0;
      tick();
    end
    chk("dt_hi_cycles", 32'(hi), 32'd8);
    chk("dt_err",    32'(vpd_err), 32'h0);
    chk("dt_data",   cap_data_rdata, 32'h1234_5678);
    chk("dt_ardata", 32'(cap_addr_rdata), 32'h8030);

    // Simultaneous data and address write in IDLE
    cap_data_wr = 1'b1; cap_data_wdata = 32'h0000_00FF;
    cap_addr_wr = 1'b1; cap_addr_wdata = 16'h8001;
    tick();
    cap_data_wr = 1'b0; cap_addr_wr = 1'b0;
    chk("sim_wren",  32'(cfg_vpd_wren), 32'h1);
    chk("sim_wdata", cfg_vpd_wdata, 32'h0000_00FF);
    chk("sim_addr",  32'(cfg_vpd_addr), 32'h001);
    chk("sim_err",   32'(vpd_err), 32'h0);
    vpd_cfg_done = 1'b1;
    tick();
    vpd_cfg_done = 1'b0;
    chk("sim_ardata", 32'(cap_addr_rdata), 32'h0001);

    // Reset in the middle of a read; later done is ignored
    addr_wr(16'h0040);
    tick();
    chk("mr_rden", 32'(cfg_vpd_rden), 32'h1);
    #2 reset = 1'b1;
    #1 chk("mr_rden_async", 32'(cfg_vpd_rden), 32'h0);
    chk("mr_busy_async", 32'(vpd_busy), 32'h0);
    tick();
    reset = 1'b0;
    vpd_cfg_done = 1'b1; vpd_cfg_rdata = 32'hCAFE_F00D;
    tick();
    vpd_cfg_done = 1'b0;
    tick();
    chk("mr_rden_after", 32'(cfg_vpd_rden), 32'h0);
    chk("mr_busy_after", 32'(vpd_busy), 32'h0);
    chk("mr_data",       cap_data_rdata, 32'h0);
    chk("mr_ardata",     32'(cap_addr_rdata), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
